// File: rtl/mult_arb_pkg.sv
// Shared types, defaults and the round-robin pick helper for the multiplier-sharing arbiter.
package mult_arb_pkg;

    localparam int unsigned DEF_W       = 2;
    localparam int unsigned DEF_NUM_REQ = 4;
    localparam int unsigned MAX_REQ     = 8;
    localparam int unsigned MAX_ID_W    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic                found;
        logic [MAX_ID_W-1:0] idx;
    } pick_t;

    // First set bit of valid searching upward from ptr, wrapping modulo num.
    function automatic pick_t rr_pick(
        input logic [MAX_REQ-1:0]  valid,
        input logic [MAX_ID_W-1:0] ptr,
        input int unsigned         num
    );
        pick_t       res;
        int unsigned cand;
        res = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            cand = (32'(ptr) + i) % num;
            if (!res.found && (i < num) && valid[MAX_ID_W'(cand)]) begin
                res.found = 1'b1;
                res.idx   = MAX_ID_W'(cand);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mult_core.sv
// Combinational unsigned WxW multiplier; full 2W-bit product.
module mult_core #(
    parameter int unsigned W = 2
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] z
);

    // Operands widened first so the product is never truncated.
    assign z = (2*W)'(a) * (2*W)'(b);

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one multiplier core between NUM_REQ requesters.
module mult_share_arbiter
    import mult_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter  int unsigned W       = DEF_W,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*W-1:0] req_a,
    input  logic [NUM_REQ*W-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [2*W-1:0]       rsp_z,
    output logic                 busy
);

    state_t            r_state;
    state_t            w_state_next;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [W-1:0]      r_op_a;
    logic [W-1:0]      r_op_b;
    logic [ID_W-1:0]   r_win_id;
    logic              r_rsp_valid;
    logic [ID_W-1:0]   r_rsp_id;
    logic [2*W-1:0]    r_rsp_z;
    logic              r_busy;

    pick_t             w_pick;
    logic [ID_W-1:0]   w_pick_id;
    logic [W-1:0]      w_win_a;
    logic [W-1:0]      w_win_b;
    logic [2*W-1:0]    w_prod;
    logic              w_accept;
    logic              w_rsp_done;
    logic [ID_W-1:0]   w_ptr_next;

    assign w_pick     = rr_pick(MAX_REQ'(req_valid), MAX_ID_W'(r_rr_ptr), NUM_REQ);
    assign w_pick_id  = ID_W'(w_pick.idx);
    assign w_ptr_next = (r_win_id == ID_W'(NUM_REQ - 1)) ? '0 : r_win_id + ID_W'(1);

    mult_core #(
        .W (W)
    ) u_mult_core (
        .a (r_op_a),
        .b (r_op_b),
        .z (w_prod)
    );

    // Operand mux selecting the current winner's packed operands.
    always_comb begin
        w_win_a = '0;
        w_win_b = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_pick_id == ID_W'(i)) begin
                w_win_a = req_a[i*W +: W];
                w_win_b = req_b[i*W +: W];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_pick.found) w_state_next = CALC;
            CALC:    w_state_next = RESP;
            RESP:    if (rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State decode: accept/complete strobes and the one-hot grant, forced low in reset.
    always_comb begin
        w_accept   = 1'b0;
        w_rsp_done = 1'b0;
        req_ready  = '0;
        w_accept   = (r_state == IDLE) && w_pick.found;
        w_rsp_done = (r_state == RESP) && rsp_ready;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = rst_n && w_accept && (w_pick_id == ID_W'(i));
        end
    end

    // Operand capture, response registers, pointer advance and busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_win_id    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_z     <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_busy <= (w_state_next != IDLE);
            if (w_accept) begin
                r_op_a   <= w_win_a;
                r_op_b   <= w_win_b;
                r_win_id <= w_pick_id;
            end
            if (r_state == CALC) begin
                r_rsp_z     <= w_prod;
                r_rsp_id    <= r_win_id;
                r_rsp_valid <= 1'b1;
            end
            if (w_rsp_done) begin
                r_rsp_valid <= 1'b0;
                r_rr_ptr    <= w_ptr_next;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_z     = r_rsp_z;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter: directed scenarios plus a randomized run against a reference model.
module tb_mult_share_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 2;
    localparam int unsigned IW = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a = '0;
    logic [N*W-1:0]   req_b = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [IW-1:0]    rsp_id;
    logic [2*W-1:0]   rsp_z;
    logic             busy;

    int n_cmp = 0;
    int n_err = 0;

    int g_id[$];
    int g_cyc[$];
    int r_id[$];
    int r_z[$];
    int cyc_no;

    always #5 clk = ~clk;

    mult_share_arbiter #(
        .NUM_REQ (N),
        .W       (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_z     (rsp_z),
        .busy      (busy)
    );

    // Tasks enter and leave 1 time unit after a rising edge; checks happen one unit later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input int a, input int b);
        req_a[i*W +: W] = W'(a);
        req_b[i*W +: W] = W'(b);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Runs ncyc cycles, dropping each request once granted, logging grants and completed responses.
    task automatic run_log(input int ncyc);
        logic [N-1:0] drop;
        drop = '0;
        g_id.delete(); g_cyc.delete(); r_id.delete(); r_z.delete();
        cyc_no = 0;
        for (int c = 0; c < ncyc; c++) begin
            req_valid = req_valid & ~drop;
            drop      = '0;
            #1;
            for (int i = 0; i < int'(N); i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    g_id.push_back(i);
                    g_cyc.push_back(cyc_no);
                    drop[i] = 1'b1;
                end
            end
            if (rsp_valid && rsp_ready) begin
                r_id.push_back(int'(rsp_id));
                r_z.push_back(int'(rsp_z));
            end
            cyc_no++;
            next_cycle();
        end
        req_valid = req_valid & ~drop;
    endtask

    task automatic test_reset();
        #2;
        rst_n     = 1'b0;
        req_valid = '1;
        req_a     = 8'hFF;
        req_b     = 8'hFF;
        @(posedge clk);
        #2;
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready got=%b exp=%b", req_ready, 4'b0000); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        n_cmp++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
        n_cmp++; if (rsp_z !== 4'd0) begin n_err++; $display("FAIL reset_rsp_z got=%0d exp=0", rsp_z); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        next_cycle();
        req_valid = '0;
        rst_n     = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_release_busy got=%b exp=0", busy); end
        next_cycle();
    endtask

    task automatic test_single();
        do_reset();
        set_req(0, 3, 3);
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_grant got=%b exp=0001", req_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_idle got=%b exp=0", busy); end
        next_cycle();
        req_valid = '0;
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_calc got=%b exp=1", busy); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_rsp_early got=%b exp=0", rsp_valid); end
        next_cycle();
        #1;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL single_rsp_valid got=%b exp=1", rsp_valid); end
        n_cmp++; if (rsp_z !== 4'd9) begin n_err++; $display("FAIL single_rsp_z got=%0d exp=9", rsp_z); end
        n_cmp++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL single_rsp_id got=%0d exp=0", rsp_id); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_resp got=%b exp=1", busy); end
        next_cycle();
        rsp_ready = 1'b1;
        #1;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_z !== 4'd9) begin n_err++; $display("FAIL single_rsp_hold got=%b/%0d exp=1/9", rsp_valid, rsp_z); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_third got=%b exp=1", busy); end
        next_cycle();
        rsp_ready = 1'b0;
        #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_rsp_done got=%b exp=0", rsp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_done got=%b exp=0", busy); end
        next_cycle();
    endtask

    task automatic test_all_four();
        do_reset();
        for (int i = 0; i < int'(N); i++) set_req(i, i, 2);
        req_valid = '1;
        rsp_ready = 1'b1;
        run_log(14);
        n_cmp++; if (g_id.size() != 4) begin n_err++; $display("FAIL all4_grant_count got=%0d exp=4", g_id.size()); end
        n_cmp++; if (r_z.size() != 4) begin n_err++; $display("FAIL all4_rsp_count got=%0d exp=4", r_z.size()); end
        for (int k = 0; k < 4; k++) begin
            if (k < g_id.size()) begin
                n_cmp++; if (g_id[k] != k) begin n_err++; $display("FAIL all4_order[%0d] got=%0d exp=%0d", k, g_id[k], k); end
                n_cmp++; if (g_cyc[k] != 3*k) begin n_err++; $display("FAIL all4_spacing[%0d] got=%0d exp=%0d", k, g_cyc[k], 3*k); end
            end
            if (k < r_z.size()) begin
                n_cmp++; if (r_z[k] != 2*k) begin n_err++; $display("FAIL all4_rsp_z[%0d] got=%0d exp=%0d", k, r_z[k], 2*k); end
                n_cmp++; if (r_id[k] != k) begin n_err++; $display("FAIL all4_rsp_id[%0d] got=%0d exp=%0d", k, r_id[k], k); end
            end
        end
    endtask

    task automatic test_wrap();
        set_req(0, 1, 3);
        set_req(3, 3, 3);
        req_valid = 4'b1001;
        rsp_ready = 1'b1;
        run_log(8);
        n_cmp++; if (g_id.size() != 2) begin n_err++; $display("FAIL wrap_grant_count got=%0d exp=2", g_id.size()); end
        if (g_id.size() == 2) begin
            n_cmp++; if (g_id[0] != 0 || g_id[1] != 3) begin n_err++; $display("FAIL wrap_order got=%0d,%0d exp=0,3", g_id[0], g_id[1]); end
        end
        if (r_z.size() == 2) begin
            n_cmp++; if (r_z[0] != 3 || r_z[1] != 9) begin n_err++; $display("FAIL wrap_rsp_z got=%0d,%0d exp=3,9", r_z[0], r_z[1]); end
            n_cmp++; if (r_id[0] != 0 || r_id[1] != 3) begin n_err++; $display("FAIL wrap_rsp_id got=%0d,%0d exp=0,3", r_id[0], r_id[1]); end
        end else begin
            n_cmp++; n_err++; $display("FAIL wrap_rsp_count got=%0d exp=2", r_z.size());
        end
    endtask

    task automatic test_backpressure();
        set_req(1, 2, 3);
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_grant1 got=%b exp=0010", req_ready); end
        next_cycle();
        set_req(2, 1, 1);
        req_valid = 4'b0100;
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_ready_calc got=%b exp=0000", req_ready); end
        next_cycle();
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_z !== 4'd6 || rsp_id !== 2'd1) begin
                n_err++; $display("FAIL bp_hold[%0d] got v=%b z=%0d id=%0d exp v=1 z=6 id=1", c, rsp_valid, rsp_z, rsp_id);
            end
            n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_no_grant[%0d] got=%b exp=0000", c, req_ready); end
            next_cycle();
        end
        rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_handshake_grant got=%b exp=0000", req_ready); end
        next_cycle();
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL bp_grant2 got=%b exp=0100", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_rsp_cleared got=%b exp=0", rsp_valid); end
        next_cycle();
        req_valid = '0;
        next_cycle();
        #1;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_z !== 4'd1 || rsp_id !== 2'd2) begin
            n_err++; $display("FAIL bp_rsp2 got v=%b z=%0d id=%0d exp v=1 z=1 id=2", rsp_valid, rsp_z, rsp_id);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        set_req(2, 3, 2);
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL rmid_grant got=%b exp=0100", req_ready); end
        next_cycle();
        req_valid = '1;
        rst_n     = 1'b0;
        #1;
        n_cmp++; if (rsp_valid !== 1'b0 || rsp_z !== 4'd0 || rsp_id !== 2'd0) begin
            n_err++; $display("FAIL rmid_rsp_cleared got v=%b z=%0d id=%0d exp 0/0/0", rsp_valid, rsp_z, rsp_id);
        end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rmid_ready_in_reset got=%b exp=0000", req_ready); end
        next_cycle();
        #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rmid_no_rsp got=%b exp=0", rsp_valid); end
        next_cycle();
        rst_n = 1'b1;
        set_req(0, 2, 2);
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rmid_ptr_zero got=%b exp=0001", req_ready); end
        next_cycle();
        req_valid = '0;
        #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rmid_calc_quiet got=%b exp=0", rsp_valid); end
        next_cycle();
        #1;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_z !== 4'd4) begin
            n_err++; $display("FAIL rmid_next_rsp got v=%b id=%0d z=%0d exp v=1 id=0 z=4", rsp_valid, rsp_id, rsp_z);
        end
        next_cycle();
    endtask

    // Randomized traffic checked against a transaction-level model of the arbiter.
    task automatic test_random();
        logic [N-1:0]   drop;
        logic [N-1:0]   exp_ready;
        int             m_ptr, m_id, m_age, win, idx, cycles, n_gr, n_rs, left;
        bit             m_busy;
        bit             exp_v[N];
        int             exp_z[N];
        bit             exp_rv;
        do_reset();
        drop = '0; m_ptr = 0; m_id = 0; m_age = 0; m_busy = 0;
        cycles = 0; n_gr = 0; n_rs = 0;
        for (int i = 0; i < int'(N); i++) begin exp_v[i] = 0; exp_z[i] = 0; end
        while (!(n_gr >= 1000 && !m_busy && req_valid == '0)) begin
            if (cycles > 40000) begin
                n_cmp++; n_err++; $display("FAIL random_budget cycles=%0d grants=%0d responses=%0d", cycles, n_gr, n_rs);
                break;
            end
            cycles++;
            req_valid = req_valid & ~drop;
            drop      = '0;
            for (int i = 0; i < int'(N); i++) begin
                if (!req_valid[i]) begin
                    if (n_gr < 1000 && $urandom_range(2) == 0) begin
                        req_valid[i] = 1'b1;
                        set_req(i, int'($urandom_range(3)), int'($urandom_range(3)));
                    end
                end else if ($urandom_range(31) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = 1'($urandom_range(1));
            #1;
            if (m_busy) m_age++;
            exp_ready = '0;
            win = -1;
            if (!m_busy) begin
                for (int k = 0; k < int'(N); k++) begin
                    idx = (m_ptr + k) % int'(N);
                    if (win < 0 && req_valid[idx]) win = idx;
                end
                if (win >= 0) exp_ready[win] = 1'b1;
            end
            n_cmp++; if (req_ready !== exp_ready) begin n_err++; $display("FAIL rand_grant cyc=%0d got=%b exp=%b", cycles, req_ready, exp_ready); end
            n_cmp++; if (busy !== m_busy) begin n_err++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cycles, busy, m_busy); end
            exp_rv = m_busy && (m_age >= 2);
            n_cmp++; if (rsp_valid !== exp_rv) begin n_err++; $display("FAIL rand_rsp_valid cyc=%0d got=%b exp=%b", cycles, rsp_valid, exp_rv); end
            drop = req_valid & req_ready;
            if (exp_rv && rsp_ready) begin
                n_rs++;
                n_cmp++; if (rsp_id !== IW'(m_id)) begin n_err++; $display("FAIL rand_rsp_id cyc=%0d got=%0d exp=%0d", cycles, rsp_id, m_id); end
                n_cmp++; if (!exp_v[m_id] || rsp_z !== (2*W)'(exp_z[m_id])) begin
                    n_err++; $display("FAIL rand_rsp_z cyc=%0d id=%0d got=%0d exp=%0d pending=%b", cycles, m_id, rsp_z, exp_z[m_id], exp_v[m_id]);
                end
                exp_v[m_id] = 0;
                m_busy = 0;
                m_ptr  = (m_id + 1) % int'(N);
            end else if (win >= 0) begin
                n_gr++;
                m_busy = 1;
                m_age  = 0;
                m_id   = win;
                exp_z[win] = int'(req_a[win*W +: W]) * int'(req_b[win*W +: W]);
                exp_v[win] = 1;
            end
            next_cycle();
        end
        req_valid = '0;
        left = 0;
        for (int i = 0; i < int'(N); i++) if (exp_v[i]) left++;
        n_cmp++; if (n_gr != n_rs) begin n_err++; $display("FAIL rand_balance grants=%0d responses=%0d", n_gr, n_rs); end
        n_cmp++; if (left != 0) begin n_err++; $display("FAIL rand_outstanding got=%0d exp=0", left); end
        n_cmp++; if (n_rs < 1000) begin n_err++; $display("FAIL rand_volume got=%0d exp>=1000", n_rs); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
